// File: rtl/chacha_pkg.sv
// rtl/chacha_pkg.sv - shared widths and FSM state type for the ChaCha keystream controller
package chacha_pkg;

  localparam int KEY_WIDTH         = 256;
  localparam int NONCE_WIDTH       = 96;
  localparam int BLOCK_COUNT_WIDTH = 32;
  localparam int WIDTH             = 32;
  localparam int OUT_WIDTH         = 512;
  localparam int WORDS_PER_BLOCK   = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STREAM = 3'd3,
    ST_FIN    = 3'd4
  } ks_state_t;

endpackage

// File: rtl/chacha_ks_serializer.sv
// rtl/chacha_ks_serializer.sv - single-buffer block capture and word serializer with ready/valid output
module chacha_ks_serializer #(
  parameter int WIDTH     = chacha_pkg::WIDTH,
  parameter int OUT_WIDTH = chacha_pkg::OUT_WIDTH,
  parameter int NWORDS    = chacha_pkg::WORDS_PER_BLOCK
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load,
  input  logic [OUT_WIDTH-1:0] load_data,
  input  logic                 last_block,
  output logic                 ks_valid,
  input  logic                 ks_ready,
  output logic [WIDTH-1:0]     ks_data,
  output logic                 ks_last,
  output logic                 block_done
);

  localparam int IDX_W = $clog2(NWORDS);

  logic [OUT_WIDTH-1:0] blk_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 valid_q;
  logic                 xfer;
  logic                 at_end;

  assign xfer       = valid_q && ks_ready;
  assign at_end     = (idx_q == IDX_W'(NWORDS - 1));
  assign block_done = xfer && at_end;

  // The buffer shifts toward the MSB, so the current word is always the top slice.
  assign ks_valid = valid_q;
  assign ks_data  = blk_q[OUT_WIDTH-1 -: WIDTH];
  assign ks_last  = valid_q && at_end && last_block;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      blk_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      blk_q   <= load_data;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      blk_q <= blk_q << WIDTH;
      if (at_end) begin
        idx_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/chacha_keystream_ctrl.sv
// rtl/chacha_keystream_ctrl.sv - ChaCha keystream command controller
// Requests one block-function result per block and streams it out as words.
module chacha_keystream_ctrl #(
  parameter int KEY_WIDTH         = chacha_pkg::KEY_WIDTH,
  parameter int NONCE_WIDTH       = chacha_pkg::NONCE_WIDTH,
  parameter int BLOCK_COUNT_WIDTH = chacha_pkg::BLOCK_COUNT_WIDTH,
  parameter int WIDTH             = chacha_pkg::WIDTH,
  parameter int OUT_WIDTH         = chacha_pkg::OUT_WIDTH,
  parameter int NBLK_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [KEY_WIDTH-1:0]         cmd_key,
  input  logic [NONCE_WIDTH-1:0]       cmd_nonce,
  input  logic [BLOCK_COUNT_WIDTH-1:0] cmd_counter,
  input  logic [NBLK_WIDTH-1:0]        cmd_nblocks,
  output logic                         bf_start,
  output logic [KEY_WIDTH-1:0]         bf_key,
  output logic [NONCE_WIDTH-1:0]       bf_nonce,
  output logic [BLOCK_COUNT_WIDTH-1:0] bf_block_count,
  input  logic                         bf_ready,
  input  logic                         bf_valid,
  input  logic [OUT_WIDTH-1:0]         bf_out,
  output logic                         ks_valid,
  input  logic                         ks_ready,
  output logic [WIDTH-1:0]             ks_data,
  output logic                         ks_last,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  import chacha_pkg::*;

  localparam int CW = BLOCK_COUNT_WIDTH + 1;

  ks_state_t                    state;
  logic [KEY_WIDTH-1:0]         key_q;
  logic [NONCE_WIDTH-1:0]       nonce_q;
  logic [BLOCK_COUNT_WIDTH-1:0] count_q;
  logic [NBLK_WIDTH-1:0]        remain_q;
  logic                         run_q;
  logic                         err_q;
  logic                         accept;
  logic                         load;
  logic                         blk_done;
  logic [CW-1:0]                last_cnt;
  logic                         overflow;

  // run_q keeps cmd_ready low through reset and raises it on the first edge after release.
  assign cmd_ready = (state == ST_IDLE) && run_q;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign err       = err_q;
  assign bf_start  = (state == ST_ISSUE) && bf_ready;
  assign load      = (state == ST_WAIT) && bf_valid;

  assign bf_key         = key_q;
  assign bf_nonce       = nonce_q;
  assign bf_block_count = count_q;

  // Counter of the final block, one bit wider so a wrap past the top shows up as overflow.
  assign last_cnt = {1'b0, cmd_counter} + CW'(cmd_nblocks) - CW'(1);
  assign overflow = (last_cnt > CW'({BLOCK_COUNT_WIDTH{1'b1}}));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      nonce_q  <= '0;
      count_q  <= '0;
      remain_q <= '0;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      run_q <= 1'b1;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            key_q    <= cmd_key;
            nonce_q  <= cmd_nonce;
            count_q  <= cmd_counter;
            remain_q <= cmd_nblocks;
            if (cmd_nblocks == '0) begin
              state <= ST_FIN;
            end else if (overflow) begin
              err_q <= 1'b1;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (bf_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bf_valid) state <= ST_STREAM;
        end
        ST_STREAM: begin
          if (blk_done) begin
            if (remain_q != NBLK_WIDTH'(1)) begin
              remain_q <= remain_q - NBLK_WIDTH'(1);
              count_q  <= count_q + BLOCK_COUNT_WIDTH'(1);
              state    <= ST_ISSUE;
            end else begin
              state <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  chacha_ks_serializer #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .NWORDS    (OUT_WIDTH / WIDTH)
  ) u_ser (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .load_data  (bf_out),
    .last_block (remain_q == NBLK_WIDTH'(1)),
    .ks_valid   (ks_valid),
    .ks_ready   (ks_ready),
    .ks_data    (ks_data),
    .ks_last    (ks_last),
    .block_done (blk_done)
  );

endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// tb/tb_chacha_keystream_ctrl.sv - directed table-driven bench with a behavioural ChaCha20 block function
module tb_chacha_keystream_ctrl;

  localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  NONCE = 96'h000000090000004a00000000;
  localparam int           BF_LAT = 3;

  logic         clk;
  logic         resetn;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [255:0] cmd_key;
  logic [95:0]  cmd_nonce;
  logic [31:0]  cmd_counter;
  logic [15:0]  cmd_nblocks;
  logic         bf_start;
  logic [255:0] bf_key;
  logic [95:0]  bf_nonce;
  logic [31:0]  bf_block_count;
  logic         bf_ready;
  logic         bf_valid;
  logic [511:0] bf_out;
  logic         ks_valid;
  logic         ks_ready;
  logic [31:0]  ks_data;
  logic         ks_last;
  logic         busy;
  logic         done;
  logic         err;

  chacha_keystream_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_key        (cmd_key),
    .cmd_nonce      (cmd_nonce),
    .cmd_counter    (cmd_counter),
    .cmd_nblocks    (cmd_nblocks),
    .bf_start       (bf_start),
    .bf_key         (bf_key),
    .bf_nonce       (bf_nonce),
    .bf_block_count (bf_block_count),
    .bf_ready       (bf_ready),
    .bf_valid       (bf_valid),
    .bf_out         (bf_out),
    .ks_valid       (ks_valid),
    .ks_ready       (ks_ready),
    .ks_data        (ks_data),
    .ks_last        (ks_last),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ctr;
    logic [15:0] nb;
    bit          bp;
    bit          inj;
    bit          err;
  } vec_t;

  vec_t vecs[8];

  int          total;
  int          bad;
  bit          bp_on;
  bit          inject_on;
  logic [31:0] words_q[$];
  logic        last_q[$];
  logic [31:0] cnt_q[$];
  int          start_cnt;
  int          done_cnt;
  int          err_cnt;
  logic        stall_q;
  logic [31:0] stall_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, input logic [31:0] b_i,
                                      input logic [31:0] c_i, input logic [31:0] d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a = a + b; d = rotl(d ^ a, 16);
    c = c + d; b = rotl(b ^ c, 12);
    a = a + b; d = rotl(d ^ a, 8);
    c = c + d; b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  // Word i of the result sits at [511-32*i -: 32], matching the keystream word order.
  function automatic logic [511:0] chacha_model(input logic [255:0] k, input logic [95:0] n,
                                                input logic [31:0] c);
    logic [31:0]  s[16];
    logic [31:0]  x[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
    x = s;
    for (int rd = 0; rd < 10; rd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = x[i] + s[i];
    return r;
  endfunction

  // Block-function stand-in: fixed latency after bf_start, optional stray bf_valid pulses.
  initial begin : bf_stub
    logic st;
    int   lat;
    bf_ready = 1'b1;
    bf_valid = 1'b0;
    bf_out   = '0;
    lat      = 0;
    forever begin
      @(negedge clk);
      st = bf_start;
      @(posedge clk);
      #1;
      bf_valid = 1'b0;
      if (!resetn) begin
        lat      = 0;
        bf_ready = 1'b1;
      end else if (st) begin
        lat      = BF_LAT;
        bf_ready = 1'b0;
      end else if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          bf_out   = chacha_model(bf_key, bf_nonce, bf_block_count);
          bf_valid = 1'b1;
          bf_ready = 1'b1;
        end
      end else if (inject_on) begin
        bf_out   = {16{32'hdeadbeef}};
        bf_valid = 1'b1;
      end
    end
  end

  initial begin : mon
    stall_q = 1'b0;
    stall_d = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q && ks_valid) chk("stall_hold", 64'(ks_data), 64'(stall_d));
        stall_q = ks_valid && !ks_ready;
        stall_d = ks_data;
        if (ks_valid && ks_ready) begin
          words_q.push_back(ks_data);
          last_q.push_back(ks_last);
        end
        if (bf_start) begin
          start_cnt++;
          cnt_q.push_back(bf_block_count);
        end
        if (done) done_cnt++;
        if (err) err_cnt++;
      end
    end
  end

  task automatic clear_mon();
    words_q.delete();
    last_q.delete();
    cnt_q.delete();
    start_cnt = 0;
    done_cnt  = 0;
    err_cnt   = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ks_ready = bp_on ? ($urandom_range(0, 99) >= 40) : 1'b1;
  endtask

  task automatic send(input logic [31:0] ctr, input logic [15:0] nb);
    int t;
    t = 0;
    while (!cmd_ready && t < 200) begin
      step();
      t++;
    end
    chk("cmd_ready_wait", 64'(t < 200), 64'(1));
    cmd_valid   = 1'b1;
    cmd_key     = KEY;
    cmd_nonce   = NONCE;
    cmd_counter = ctr;
    cmd_nblocks = nb;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t         v;
    int           t;
    int           nexp;
    int           nblk;
    int           nlast;
    logic [511:0] blk;
    v         = vecs[i];
    bp_on     = v.bp;
    inject_on = v.inj;
    nblk      = v.err ? 0 : int'(v.nb);
    nexp      = nblk * 16;
    clear_mon();
    send(v.ctr, v.nb);
    @(negedge clk);
    chk($sformatf("v%0d_err_pulse", i), 64'(err), 64'(v.err));
    chk($sformatf("v%0d_done_early", i), 64'(done), 64'(v.nb == 16'd0));
    chk($sformatf("v%0d_first_start", i), 64'(bf_start), 64'(!v.err && v.nb != 16'd0));
    chk($sformatf("v%0d_bf_key", i), 64'(bf_key == KEY), 64'(1));
    chk($sformatf("v%0d_bf_nonce", i), 64'(bf_nonce), 64'(NONCE));
    if (v.err || v.nb == 16'd0) begin
      @(negedge clk);
      chk($sformatf("v%0d_ready_after", i), 64'(cmd_ready), 64'(1));
      chk($sformatf("v%0d_pulse_width", i), 64'(err || done), 64'(0));
    end
    t = 0;
    while (done_cnt + err_cnt == 0 && t < 4000) begin
      step();
      t++;
    end
    chk($sformatf("v%0d_timeout", i), 64'(t < 4000), 64'(1));
    step();
    step();
    chk($sformatf("v%0d_done_cnt", i), 64'(done_cnt), 64'(v.err ? 0 : 1));
    chk($sformatf("v%0d_err_cnt", i), 64'(err_cnt), 64'(v.err ? 1 : 0));
    chk($sformatf("v%0d_starts", i), 64'(start_cnt), 64'(nblk));
    chk($sformatf("v%0d_nwords", i), 64'(words_q.size()), 64'(nexp));
    for (int k = 0; k < nblk && k < cnt_q.size(); k++)
      chk($sformatf("v%0d_cnt%0d", i, k), 64'(cnt_q[k]), 64'(v.ctr + 32'(k)));
    for (int k = 0; k < nblk; k++) begin
      blk = chacha_model(KEY, NONCE, v.ctr + 32'(k));
      for (int j = 0; j < 16 && (16*k + j) < words_q.size(); j++)
        chk($sformatf("v%0d_b%0d_w%0d", i, k, j), 64'(words_q[16*k+j]), 64'(blk[511-32*j -: 32]));
    end
    nlast = 0;
    foreach (last_q[j]) if (last_q[j]) nlast++;
    chk($sformatf("v%0d_last_cnt", i), 64'(nlast), 64'(nexp > 0 ? 1 : 0));
    if (nexp > 0 && last_q.size() == nexp)
      chk($sformatf("v%0d_last_pos", i), 64'(last_q[nexp-1]), 64'(1));
    chk($sformatf("v%0d_idle", i), 64'(busy), 64'(0));
  endtask

  initial begin : main
    int t;
    total = 0;
    bad   = 0;
    vecs[0] = '{32'h00000001, 16'd1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFFFFFD, 16'd3, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFFFFFF, 16'd2, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h00000000, 16'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 16'd1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'hFFFFFFFE, 16'd3, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'h00000010, 16'd2, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFFFFFE, 16'd2, 1'b1, 1'b0, 1'b0};

    resetn      = 1'b0;
    cmd_valid   = 1'b0;
    cmd_key     = '0;
    cmd_nonce   = '0;
    cmd_counter = '0;
    cmd_nblocks = '0;
    ks_ready    = 1'b1;
    bp_on       = 1'b0;
    inject_on   = 1'b0;
    clear_mon();

    repeat (2) @(posedge clk);
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ks_valid", 64'(ks_valid), 64'(0));
    chk("rst_pulses", 64'({done, err, bf_start, ks_last}), 64'(0));
    chk("rst_ks_data", 64'(ks_data), 64'(0));
    chk("rst_bf_count", 64'(bf_block_count), 64'(0));
    chk("rst_bf_key", 64'(bf_key == '0), 64'(1));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ready_before_edge", 64'(cmd_ready), 64'(0));
    @(posedge clk);
    #1;
    chk("ready_first_edge", 64'(cmd_ready), 64'(1));

    for (int i = 0; i < 8; i++) begin
      run_vec(i);
      if (i == 0 && words_q.size() > 0)
        chk("rfc_word0", 64'(words_q[0]), 64'(32'he4e7f110));
    end

    bp_on     = 1'b0;
    inject_on = 1'b0;
    clear_mon();
    send(32'h00000005, 16'd1);
    t = 0;
    while (words_q.size() < 7 && t < 500) begin
      step();
      t++;
    end
    chk("mid_reset_reach", 64'(t < 500), 64'(1));
    chk("mid_reset_streaming", 64'(ks_valid), 64'(1));
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_reset_ks_valid", 64'(ks_valid), 64'(0));
    chk("mid_reset_busy", 64'(busy), 64'(0));
    chk("mid_reset_done", 64'(done), 64'(0));
    chk("mid_reset_ks_data", 64'(ks_data), 64'(0));
    chk("mid_reset_bf_count", 64'(bf_block_count), 64'(0));
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;
    clear_mon();
    repeat (6) step();
    chk("post_reset_done", 64'(done_cnt), 64'(0));
    chk("post_reset_err", 64'(err_cnt), 64'(0));
    chk("post_reset_words", 64'(words_q.size()), 64'(0));
    chk("post_reset_starts", 64'(start_cnt), 64'(0));
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
